// File: rtl/ofdm_cnt_pkg.sv
// Shared constants for the OFDM RX timing counters.
//   CNT_UP   : stage counts 0 .. limit, then reloads 0.
//   CNT_DOWN : stage counts limit .. 0, then reloads limit.
package ofdm_cnt_pkg;

   localparam logic CNT_UP   = 1'b0;
   localparam logic CNT_DOWN = 1'b1;

endpackage

// File: rtl/cnt_stage.sv
// One digit of the cascade counter: a W-bit count that steps by +/-1 and
// reloads its start value when stepped at its terminal value.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear to clr_val (highest priority)
//   load         synchronous preload from load_val (already clamped to limit)
//   step         carry into this stage; advance by one
//   wrap         the whole cascade wraps this cycle; reload from clr_val
//   clr_val      start value built from the incoming limit / direction
//   load_val     preload value
//   limit_q      shadowed terminal value
//   dir_q        shadowed direction (CNT_UP / CNT_DOWN)
//   count        registered count
//   term         count is at its terminal value (not gated by arming)
module cnt_stage
   import ofdm_cnt_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic         step,
   input  logic         wrap,
   input  logic [W-1:0] clr_val,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] limit_q,
   input  logic         dir_q,
   output logic [W-1:0] count,
   output logic         term
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic [W-1:0] restart_val;

   assign term = (dir_q == CNT_DOWN) ? (count_q == '0) : (count_q == limit_q);

   // Reload within a frame uses the shadowed settings; on a full wrap the
   // start value comes from the freshly latched limit/direction instead.
   assign restart_val = wrap ? clr_val : ((dir_q == CNT_DOWN) ? limit_q : '0);

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = clr_val;
      end else if (load) begin
         count_d = load_val;
      end else if (step) begin
         if (term) begin
            count_d = restart_val;
         end else if (dir_q == CNT_DOWN) begin
            count_d = count_q - W'(1);
         end else begin
            count_d = count_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cascade_counter.sv
// Multi-stage nested counter for OFDM RX timing (sample/symbol/frame counts).
// Stage 0 is least significant; each stage has its own terminal value, held in
// shadow registers that only update at latch points (clr, load, full wrap).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           count enable (ignored while disarmed)
//   clr          clear to start values, latch limits/direction, arm
//   load         preload min(load_val, limit), latch limits/direction, arm
//   mode_down    0 = up, 1 = down; sampled only at latch points
//   limit        per-stage terminal values, stage k at [k*W +: W]
//   load_val     per-stage preload values, same packing
//   cnt          registered stage counts
//   stage_last   per-stage terminal flags (0 while disarmed)
//   all_last     every stage terminal
//   wrap_pulse   one-cycle strobe the cycle after a full wrap
//   wrap_cnt     saturating count of full wraps since clr
//   armed        counter armed
module cascade_counter
   import ofdm_cnt_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 3,
   parameter int unsigned W          = 8,
   parameter int unsigned WRAP_W     = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    clr,
   input  logic                    load,
   input  logic                    mode_down,
   input  logic [NUM_STAGES*W-1:0] limit,
   input  logic [NUM_STAGES*W-1:0] load_val,
   output logic [NUM_STAGES*W-1:0] cnt,
   output logic [NUM_STAGES-1:0]   stage_last,
   output logic                    all_last,
   output logic                    wrap_pulse,
   output logic [WRAP_W-1:0]       wrap_cnt,
   output logic                    armed
);

   logic [NUM_STAGES*W-1:0] limit_q;
   logic [NUM_STAGES*W-1:0] limit_d;
   logic                    dir_q;
   logic                    dir_d;
   logic                    armed_q;
   logic                    armed_d;
   logic                    wrap_pulse_q;
   logic                    wrap_pulse_d;
   logic [WRAP_W-1:0]       wrap_cnt_q;
   logic [WRAP_W-1:0]       wrap_cnt_d;

   logic [NUM_STAGES-1:0]   stage_term;
   logic [NUM_STAGES-1:0]   carry;
   logic                    advance;
   logic                    full_wrap;
   logic                    latch;

   // Terminal flags depend only on registered state, so en never reaches an
   // output combinationally.
   assign stage_last = armed_q ? stage_term : '0;
   assign all_last   = &stage_last;

   // clr and load each override en; only a bare enabled step advances.
   assign advance   = en && armed_q && !clr && !load;
   assign full_wrap = advance && all_last;
   assign latch     = clr || load || full_wrap;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      logic [W-1:0] lim_in;
      logic [W-1:0] lv_in;
      logic [W-1:0] start_val;
      logic [W-1:0] load_clamped;

      assign lim_in       = limit[k*W +: W];
      assign lv_in        = load_val[k*W +: W];
      assign start_val    = (mode_down == CNT_DOWN) ? lim_in : '0;
      assign load_clamped = (lv_in > lim_in) ? lim_in : lv_in;

      if (k == 0) begin : g_carry0
         assign carry[k] = advance;
      end else begin : g_carryk
         assign carry[k] = carry[k-1] && stage_last[k-1];
      end

      cnt_stage #(
         .W(W)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr     (clr),
         .load    (load),
         .step    (carry[k]),
         .wrap    (full_wrap),
         .clr_val (start_val),
         .load_val(load_clamped),
         .limit_q (limit_q[k*W +: W]),
         .dir_q   (dir_q),
         .count   (cnt[k*W +: W]),
         .term    (stage_term[k])
      );
   end

   always_comb begin
      limit_d      = limit_q;
      dir_d        = dir_q;
      armed_d      = armed_q;
      wrap_pulse_d = full_wrap;
      wrap_cnt_d   = wrap_cnt_q;

      if (latch) begin
         limit_d = limit;
         dir_d   = mode_down;
      end

      if (clr || load) begin
         armed_d = 1'b1;
      end

      if (clr) begin
         wrap_cnt_d = '0;
      end else if (full_wrap && (wrap_cnt_q != '1)) begin
         wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         limit_q      <= '0;
         dir_q        <= CNT_UP;
         armed_q      <= 1'b0;
         wrap_pulse_q <= 1'b0;
         wrap_cnt_q   <= '0;
      end else begin
         limit_q      <= limit_d;
         dir_q        <= dir_d;
         armed_q      <= armed_d;
         wrap_pulse_q <= wrap_pulse_d;
         wrap_cnt_q   <= wrap_cnt_d;
      end
   end

   assign wrap_pulse = wrap_pulse_q;
   assign wrap_cnt   = wrap_cnt_q;
   assign armed      = armed_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Self-checking bench for cascade_counter. The reference model treats the
// cascade as a single mixed-radix position within a frame.
module tb_cascade_counter;

   localparam int NS = 3;
   localparam int W  = 8;

   logic            clk;
   logic            rst_n;
   logic            en;
   logic            clr;
   logic            load;
   logic            mode_down;
   logic [NS*W-1:0] limit;
   logic [NS*W-1:0] load_val;

   logic [NS*W-1:0] cnt;
   logic [NS-1:0]   stage_last;
   logic            all_last;
   logic            wrap_pulse;
   logic [15:0]     wrap_cnt;
   logic            armed;

   logic [NS*W-1:0] cnt2;
   logic [NS-1:0]   stage_last2;
   logic            all_last2;
   logic            wrap_pulse2;
   logic [1:0]      wrap_cnt2;
   logic            armed2;

   int total;
   int bad;

   // Reference model state.
   int m_lim[NS];
   bit m_dir;
   int m_pos;
   bit m_armed;
   int m_wc;
   int m_wc2;
   bit m_pulse;

   cascade_counter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clr       (clr),
      .load      (load),
      .mode_down (mode_down),
      .limit     (limit),
      .load_val  (load_val),
      .cnt       (cnt),
      .stage_last(stage_last),
      .all_last  (all_last),
      .wrap_pulse(wrap_pulse),
      .wrap_cnt  (wrap_cnt),
      .armed     (armed)
   );

   cascade_counter #(
      .WRAP_W(2)
   ) dut_w2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clr       (clr),
      .load      (load),
      .mode_down (mode_down),
      .limit     (limit),
      .load_val  (load_val),
      .cnt       (cnt2),
      .stage_last(stage_last2),
      .all_last  (all_last2),
      .wrap_pulse(wrap_pulse2),
      .wrap_cnt  (wrap_cnt2),
      .armed     (armed2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int weight(int k);
      int w = 1;
      for (int j = 0; j < k; j++) w = w * (m_lim[j] + 1);
      return w;
   endfunction

   function automatic int frame_len();
      return weight(NS);
   endfunction

   function automatic int digit(int k);
      return (m_pos / weight(k)) % (m_lim[k] + 1);
   endfunction

   function automatic logic [NS*W-1:0] exp_cnt();
      logic [NS*W-1:0] v = '0;
      for (int k = 0; k < NS; k++) begin
         int c = m_dir ? (m_lim[k] - digit(k)) : digit(k);
         v[k*W +: W] = W'(c);
      end
      return v;
   endfunction

   function automatic logic [NS-1:0] exp_last();
      logic [NS-1:0] v = '0;
      for (int k = 0; k < NS; k++) v[k] = m_armed && (digit(k) == m_lim[k]);
      return v;
   endfunction

   function automatic logic [45:0] exp_all();
      logic [NS-1:0] l = exp_last();
      logic [15:0] w = 16'(m_wc);
      return {exp_cnt(), l, &l, m_pulse, w, m_armed};
   endfunction

   function automatic logic [31:0] exp_all2();
      logic [NS-1:0] l = exp_last();
      logic [1:0] w = 2'(m_wc2);
      return {exp_cnt(), l, &l, m_pulse, w, m_armed};
   endfunction

   function automatic void latch_settings();
      for (int k = 0; k < NS; k++) m_lim[k] = int'(limit[k*W +: W]);
      m_dir = mode_down;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < NS; k++) m_lim[k] = 0;
      m_dir = 0; m_pos = 0; m_armed = 0; m_wc = 0; m_wc2 = 0; m_pulse = 0;
   endfunction

   function automatic void model_step();
      if (clr) begin
         latch_settings();
         m_pos = 0; m_armed = 1; m_wc = 0; m_wc2 = 0; m_pulse = 0;
      end else if (load) begin
         latch_settings();
         m_pos = 0;
         for (int k = 0; k < NS; k++) begin
            int lv = int'(load_val[k*W +: W]);
            int c  = (lv > m_lim[k]) ? m_lim[k] : lv;
            int d  = m_dir ? (m_lim[k] - c) : c;
            m_pos = m_pos + d * weight(k);
         end
         m_armed = 1; m_pulse = 0;
      end else if (en && m_armed) begin
         if (m_pos == frame_len() - 1) begin
            latch_settings();
            m_pos = 0;
            if (m_wc < 65535) m_wc++;
            if (m_wc2 < 3) m_wc2++;
            m_pulse = 1;
         end else begin
            m_pos++;
            m_pulse = 0;
         end
      end else begin
         m_pulse = 0;
      end
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en = 0; clr = 0; load = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      mode_down = 0; limit = 24'h020301; load_val = '0;
      rst_n = 0;
      model_reset();
      #23;
      rst_n = 1;
      @(posedge clk); #1;
      total++;
      if ({cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed} !== exp_all()) begin
         bad++;
         $display("FAIL reset_state: got %h expected %h",
                  {cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed}, exp_all());
      end
      en = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (cnt !== '0 || stage_last !== '0 || armed !== 1'b0) begin
            bad++;
            $display("FAIL disarmed_en: got cnt=%h last=%b armed=%b expected 0", cnt,
                     stage_last, armed);
         end
      end
      idle_inputs();
   endtask

   task automatic test_up_count();
      mode_down = 0; limit = 24'h020301;
      clr = 1; tick(); clr = 0;
      en = 1;
      for (int i = 0; i < 24; i++) begin
         tick();
         total++;
         if ({cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed} !== exp_all()) begin
            bad++;
            $display("FAIL up_step%0d: got %h expected %h", i,
                     {cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed}, exp_all());
         end
         if (i == 22) begin
            total++;
            if (cnt !== 24'h020301 || all_last !== 1'b1) begin
               bad++;
               $display("FAIL up_terminal: got cnt=%h all_last=%b expected 020301/1", cnt,
                        all_last);
            end
         end
      end
      total++;
      if (cnt !== 24'h0 || wrap_pulse !== 1'b1 || wrap_cnt !== 16'd1) begin
         bad++;
         $display("FAIL up_wrap: got cnt=%h pulse=%b wc=%0d expected 0/1/1", cnt,
                  wrap_pulse, wrap_cnt);
      end
      en = 0; tick();
      total++;
      if (wrap_pulse !== 1'b0 || wrap_cnt !== 16'd1) begin
         bad++;
         $display("FAIL up_pulse_once: got pulse=%b wc=%0d expected 0/1", wrap_pulse, wrap_cnt);
      end
   endtask

   task automatic test_priority_load();
      mode_down = 0; limit = 24'h020301; load_val = 24'h010201;
      clr = 1; load = 1; en = 1; tick();
      total++;
      if (cnt !== 24'h0 || wrap_cnt !== 16'd0 || armed !== 1'b1) begin
         bad++;
         $display("FAIL priority_clr: got cnt=%h wc=%0d armed=%b expected 0/0/1", cnt,
                  wrap_cnt, armed);
      end
      clr = 0; load = 1; en = 1; load_val = 24'h010700; tick();
      total++;
      if (cnt !== 24'h010300) begin
         bad++;
         $display("FAIL load_clamp: got %h expected 010300", cnt);
      end
      total++;
      if ({cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed} !== exp_all()) begin
         bad++;
         $display("FAIL load_model: got %h expected %h",
                  {cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed}, exp_all());
      end
      idle_inputs();
   endtask

   task automatic test_down_count();
      mode_down = 1; limit = 24'h020301;
      clr = 1; tick(); clr = 0;
      total++;
      if (cnt !== 24'h020301) begin
         bad++;
         $display("FAIL down_clr: got %h expected 020301", cnt);
      end
      en = 1;
      for (int i = 0; i < 24; i++) begin
         tick();
         total++;
         if ({cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed} !== exp_all()) begin
            bad++;
            $display("FAIL down_step%0d: got %h expected %h", i,
                     {cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed}, exp_all());
         end
         if (i == 22) begin
            total++;
            if (cnt !== 24'h0 || all_last !== 1'b1) begin
               bad++;
               $display("FAIL down_terminal: got cnt=%h all_last=%b expected 0/1", cnt,
                        all_last);
            end
         end
      end
      total++;
      if (cnt !== 24'h020301 || wrap_pulse !== 1'b1) begin
         bad++;
         $display("FAIL down_wrap: got cnt=%h pulse=%b expected 020301/1", cnt, wrap_pulse);
      end
      idle_inputs();
   endtask

   task automatic test_shadow_limits();
      mode_down = 0; limit = 24'h020301;
      clr = 1; tick(); clr = 0;
      en = 1;
      for (int i = 0; i < 24; i++) begin
         if (i == 5) begin
            limit = 24'h020304;
            mode_down = 1;
         end
         if (i == 20) mode_down = 0;
         tick();
         total++;
         if ({cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed} !== exp_all()) begin
            bad++;
            $display("FAIL shadow_step%0d: got %h expected %h", i,
                     {cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed}, exp_all());
         end
         if (i == 22) begin
            total++;
            if (cnt[7:0] !== 8'd1 || all_last !== 1'b1) begin
               bad++;
               $display("FAIL shadow_old_limit: got s0=%0d all_last=%b expected 1/1",
                        cnt[7:0], all_last);
            end
         end
      end
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (cnt !== 24'h000004) begin
         bad++;
         $display("FAIL shadow_new_limit: got %h expected 000004", cnt);
      end
      idle_inputs();
   endtask

   task automatic test_limit_zero();
      mode_down = 0; limit = 24'h050500;
      clr = 1; tick(); clr = 0;
      en = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (cnt[15:8] !== 8'(i + 1) || cnt[7:0] !== 8'd0 || stage_last[0] !== 1'b1) begin
            bad++;
            $display("FAIL limit_zero%0d: got %h expected s1=%0d s0=0", i, cnt, i + 1);
         end
      end
      idle_inputs();
   endtask

   task automatic test_wrap_saturate();
      mode_down = 0; limit = '0;
      clr = 1; tick(); clr = 0;
      en = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if ({cnt2, stage_last2, all_last2, wrap_pulse2, wrap_cnt2, armed2} !== exp_all2()) begin
            bad++;
            $display("FAIL sat_step%0d: got %h expected %h", i,
                     {cnt2, stage_last2, all_last2, wrap_pulse2, wrap_cnt2, armed2}, exp_all2());
         end
      end
      total++;
      if (wrap_cnt2 !== 2'd3 || wrap_cnt !== 16'd5) begin
         bad++;
         $display("FAIL wrap_saturate: got w2=%0d w16=%0d expected 3/5", wrap_cnt2, wrap_cnt);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      mode_down = 0; limit = 24'h010201;
      clr = 1; tick(); clr = 0;
      for (int i = 0; i < 400; i++) begin
         int r = $urandom_range(0, 99);
         clr  = (r < 2);
         load = (r >= 2 && r < 5);
         en   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) mode_down = ~mode_down;
         if ($urandom_range(0, 7) == 0) begin
            for (int k = 0; k < NS; k++) limit[k*W +: W] = 8'($urandom_range(0, 3));
         end
         for (int k = 0; k < NS; k++) load_val[k*W +: W] = 8'($urandom_range(0, 5));
         tick();
         total++;
         if ({cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed} !== exp_all() ||
             {cnt2, stage_last2, all_last2, wrap_pulse2, wrap_cnt2, armed2} !== exp_all2()) begin
            bad++;
            $display("FAIL random%0d: got %h/%h expected %h/%h", i,
                     {cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed},
                     {cnt2, stage_last2, all_last2, wrap_pulse2, wrap_cnt2, armed2},
                     exp_all(), exp_all2());
         end
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      mode_down = 0; limit = 24'h020301;
      clr = 1; tick(); clr = 0;
      en = 1;
      for (int i = 0; i < 23; i++) tick();
      #3;
      rst_n = 0;
      model_reset();
      #1;
      total++;
      if ({cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed} !== exp_all() ||
          armed !== 1'b0 || cnt !== '0) begin
         bad++;
         $display("FAIL async_reset: got %h expected %h",
                  {cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed}, exp_all());
      end
      idle_inputs();
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      total++;
      if ({cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed} !== 46'h0) begin
         bad++;
         $display("FAIL post_reset: got %h expected 0",
                  {cnt, stage_last, all_last, wrap_pulse, wrap_cnt, armed});
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_up_count();
      test_priority_load();
      test_down_count();
      test_shadow_limits();
      test_limit_zero();
      test_wrap_saturate();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
